serial_tx_dff: RTL and testbench

SERIAL_TX_DFF -- requirements
Module: serial_tx_dff

---
 rtl/serial_pkg.sv | 24 ++
 rtl/ser_shift_reg.sv | 53 +++++
 rtl/serial_tx_dff.sv | 159 +++++++++++++++
 tb/tb_serial_tx_dff.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// serial_pkg: shared definitions for the serial transmitter slice.
//   state_e      - transmitter FSM state encoding
//   WIDTH_DEF    - default number of data bits per frame
//   DIV_DEF      - default number of clk cycles per serial bit
//   LINE_IDLE    - level of the serial line when no frame is sent
//   cnt_w()      - counter width for a modulus n, never below 1 bit
package serial_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_e;

  localparam int unsigned WIDTH_DEF = 8;
  localparam int unsigned DIV_DEF   = 4;
  localparam logic        LINE_IDLE = 1'b1;

  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ser_shift_reg.sv
// ser_shift_reg: right-shifting register built from one D flip-flop cell per bit.
//   clk     - system clock
//   reset   - synchronous active-low reset, clears every cell
//   load_i  - parallel load of data_i (has priority over shift_i)
//   shift_i - shift one place towards the LSB, 0 enters at the MSB
//   data_i  - parallel load word
//   lsb_o   - current bit 0
//   nxt_o   - current bit 1, i.e. the LSB after the next shift
module ser_shift_reg #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             lsb_o,
  output logic             nxt_o
);

  logic [WIDTH-1:0] sr_q;
  logic [WIDTH-1:0] shr;

  assign shr = {1'b0, sr_q[WIDTH-1:1]};

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    logic bit_d;
    logic bit_q;

    always_comb begin
      bit_d = bit_q;
      if (load_i) begin
        bit_d = data_i[i];
      end else if (shift_i) begin
        bit_d = shr[i];
      end
    end

    always_ff @(posedge clk) begin
      if (!reset) begin
        bit_q <= 1'b0;
      end else begin
        bit_q <= bit_d;
      end
    end

    assign sr_q[i] = bit_q;
  end

  assign lsb_o = sr_q[0];
  assign nxt_o = sr_q[1];

endmodule

// File: rtl/serial_tx_dff.sv
// serial_tx_dff: parallel-to-serial frame transmitter (start bit, WIDTH data
// bits LSB first, stop bit), DIV clk cycles per serial bit.
//   clk     - system clock, rising edge
//   reset   - synchronous active-low reset
//   load    - request to send data_in (accepted only while ready)
//   data_in - parallel word to send
//   ready   - block accepts load (IDLE)
//   sout    - serial line, idles high
//   busy    - a frame is on sout
//   done    - one-cycle pulse on the final cycle of the stop bit
module serial_tx_dff
  import serial_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned DIV   = DIV_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] data_in,
  output logic             ready,
  output logic             sout,
  output logic             busy,
  output logic             done
);

  localparam int unsigned DIV_W = cnt_w(DIV);
  localparam int unsigned IDX_W = cnt_w(WIDTH);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             sout_q, sout_d;
  logic             busy_q, busy_d;
  logic             ready_q, ready_d;
  logic             done_q, done_d;

  logic             sr_load;
  logic             sr_shift;
  logic             sr_lsb;
  logic             sr_nxt;
  logic             bit_end;

  ser_shift_reg #(
    .WIDTH (WIDTH)
  ) u_shift (
    .clk     (clk),
    .reset   (reset),
    .load_i  (sr_load),
    .shift_i (sr_shift),
    .data_i  (data_in),
    .lsb_o   (sr_lsb),
    .nxt_o   (sr_nxt)
  );

  assign bit_end = (div_q == DIV_LAST);

  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    idx_d    = idx_q;
    sr_load  = 1'b0;
    sr_shift = 1'b0;

    case (state_q)
      IDLE: begin
        if (load && ready_q) begin
          state_d = START;
          div_d   = '0;
          idx_d   = '0;
          sr_load = 1'b1;
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          div_d   = '0;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      DATA: begin
        if (bit_end) begin
          div_d    = '0;
          sr_shift = 1'b1;
          if (idx_q == IDX_LAST) begin
            state_d = STOP;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      STOP: begin
        if (bit_end) begin
          state_d = IDLE;
          div_d   = '0;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        div_d   = '0;
      end
    endcase

    // Outputs are flops loaded with the value belonging to the next cycle.
    // The shift register updates on the same edge, so the next data bit is
    // taken from its pre-shift view: bit 0 on entry to DATA, bit 1 on a shift.
    sout_d = sout_q;
    case (state_d)
      IDLE:  sout_d = LINE_IDLE;
      START: sout_d = 1'b0;
      DATA: begin
        if (state_q == START) begin
          sout_d = sr_lsb;
        end else if (sr_shift) begin
          sout_d = sr_nxt;
        end
      end
      STOP:  sout_d = 1'b1;
      default: sout_d = LINE_IDLE;
    endcase

    busy_d  = (state_d != IDLE);
    ready_d = (state_d == IDLE);
    done_d  = (state_d == STOP) && (div_d == DIV_LAST);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      div_q   <= '0;
      idx_q   <= '0;
      sout_q  <= LINE_IDLE;
      busy_q  <= 1'b0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      idx_q   <= idx_d;
      sout_q  <= sout_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
      done_q  <= done_d;
    end
  end

  assign sout  = sout_q;
  assign busy  = busy_q;
  assign ready = ready_q;
  assign done  = done_q;

endmodule

// File: tb/tb_serial_tx_dff.sv
module tb_serial_tx_dff;

  typedef struct packed {
    logic sout;
    logic busy;
    logic ready;
    logic done;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       load = 1'b0;
  logic [7:0] data_in = '0;
  logic       ready, sout, busy, done;

  logic       load2 = 1'b0;
  logic [1:0] data2 = '0;
  logic       ready2, sout2, busy2, done2;

  exp_t exp_q[$];
  int unsigned n_chk = 0;
  int unsigned n_pass = 0;

  always #5 clk = ~clk;

  serial_tx_dff #(
    .WIDTH (8),
    .DIV   (4)
  ) u_dut (
    .clk     (clk),
    .reset   (reset),
    .load    (load),
    .data_in (data_in),
    .ready   (ready),
    .sout    (sout),
    .busy    (busy),
    .done    (done)
  );

  serial_tx_dff #(
    .WIDTH (2),
    .DIV   (1)
  ) u_dut2 (
    .clk     (clk),
    .reset   (reset),
    .load    (load2),
    .data_in (data2),
    .ready   (ready2),
    .sout    (sout2),
    .busy    (busy2),
    .done    (done2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model of one frame, one queue entry per clk cycle.
  task automatic push_frame(input logic [15:0] d, input int unsigned w, input int unsigned dv);
    for (int unsigned c = 0; c < dv; c++) exp_q.push_back('{1'b0, 1'b1, 1'b0, 1'b0});
    for (int unsigned b = 0; b < w; b++)
      for (int unsigned c = 0; c < dv; c++) exp_q.push_back('{d[b], 1'b1, 1'b0, 1'b0});
    for (int unsigned c = 0; c < dv; c++)
      exp_q.push_back('{1'b1, 1'b1, 1'b0, (c == dv - 1) ? 1'b1 : 1'b0});
  endtask

  task automatic push_idle(input int unsigned n);
    for (int unsigned c = 0; c < n; c++) exp_q.push_back('{1'b1, 1'b0, 1'b1, 1'b0});
  endtask

  // Called at the negedge of cycle 1 of a sequence. Each iteration compares
  // one cycle, then drives the inputs seen by the edge that ends that cycle.
  task automatic drain(input string name, input bit dut2, input bit hold,
                       input int unsigned inj_cyc, input logic [7:0] inj_d,
                       input int unsigned rst_cyc);
    exp_t e;
    int unsigned c;
    c = 1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (dut2) begin
        check($sformatf("%s.sout@%0d", name, c), 32'(sout2), 32'(e.sout));
        check($sformatf("%s.busy@%0d", name, c), 32'(busy2), 32'(e.busy));
        check($sformatf("%s.ready@%0d", name, c), 32'(ready2), 32'(e.ready));
        check($sformatf("%s.done@%0d", name, c), 32'(done2), 32'(e.done));
      end else begin
        check($sformatf("%s.sout@%0d", name, c), 32'(sout), 32'(e.sout));
        check($sformatf("%s.busy@%0d", name, c), 32'(busy), 32'(e.busy));
        check($sformatf("%s.ready@%0d", name, c), 32'(ready), 32'(e.ready));
        check($sformatf("%s.done@%0d", name, c), 32'(done), 32'(e.done));
        if (hold) begin
          load = 1'b1;
        end else if (c == inj_cyc) begin
          load = 1'b1;
          data_in = inj_d;
        end else begin
          load = 1'b0;
        end
        reset = (c == rst_cyc) ? 1'b0 : 1'b1;
      end
      c++;
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset for two cycles; a load in the last reset cycle must be ignored.
    reset = 1'b0;
    @(negedge clk);
    load = 1'b1;
    data_in = 8'hA5;
    @(negedge clk);
    reset = 1'b1;
    load = 1'b0;
    push_idle(10);
    drain("idle", 1'b0, 1'b0, 0, 8'h00, 0);

    // Single frame A5.
    load = 1'b1;
    data_in = 8'hA5;
    @(negedge clk);
    push_frame(16'h00A5, 8, 4);
    push_idle(3);
    drain("a5", 1'b0, 1'b0, 0, 8'h00, 0);

    // Load of FF while busy in cycle 10 must not disturb frame 0F.
    load = 1'b1;
    data_in = 8'h0F;
    @(negedge clk);
    push_frame(16'h000F, 8, 4);
    push_idle(3);
    drain("busyld", 1'b0, 1'b0, 10, 8'hFF, 0);

    // Back-to-back with load held: 00 then FF, one idle cycle between.
    load = 1'b1;
    data_in = 8'h00;
    @(negedge clk);
    data_in = 8'hFF;
    push_frame(16'h0000, 8, 4);
    push_idle(1);
    push_frame(16'h00FF, 8, 4);
    drain("b2b", 1'b0, 1'b1, 0, 8'h00, 0);
    load = 1'b0;
    push_idle(3);
    drain("b2b_tail", 1'b0, 1'b0, 0, 8'h00, 0);

    // Reset in cycle 20 of frame 55: idle next cycle, no done afterwards.
    load = 1'b1;
    data_in = 8'h55;
    @(negedge clk);
    push_frame(16'h0055, 8, 4);
    while (exp_q.size() > 20) void'(exp_q.pop_back());
    push_idle(30);
    drain("rstmid", 1'b0, 1'b0, 0, 8'h00, 20);

    // DIV=1, WIDTH=2 instance: 2'b10 -> 0,0,1,1 with done on cycle 4.
    load2 = 1'b1;
    data2 = 2'b10;
    @(negedge clk);
    load2 = 1'b0;
    push_frame(16'h0002, 2, 1);
    push_idle(3);
    drain("div1", 1'b1, 1'b0, 0, 8'h00, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
